// File: rtl/conv1d_stream_pkg.sv
// Shared types and helpers for the streaming 1-D convolution engine.
// Holds the FSM state type, the Q-format fraction width and the output saturator.
package conv1d_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    SCALE,
    EMIT,
    DONE
  } state_t;

  localparam int FRAC_BITS = 8;

  // Clamp a wide signed value into the signed range of a 'width'-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/conv1d_stream_mac.sv
// Signed multiply-accumulate slice: one DW x DW product added per enabled cycle.
// The accumulator is sized by the parent so that a full dot product cannot overflow.
module conv_mac
  import conv1d_stream_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 38
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  assign prod = (2*DW)'(a) * (2*DW)'(b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};
    end
  end

endmodule

// File: rtl/conv1d_stream.sv
// Multi-channel strided 1-D convolution over a captured frame, one MAC per cycle,
// results streamed out oc-major / pos-minor over a valid/ready handshake.
module conv1d_stream
  import conv1d_stream_pkg::*;
#(
  parameter int IN_CH  = 4,
  parameter int IN_LEN = 10,
  parameter int K_LEN  = 6,
  parameter int OUT_CH = 1,
  parameter int STRIDE = 2,
  parameter int DW     = 16,
  parameter int OW     = 24,
  localparam int OUT_LEN = (IN_LEN - K_LEN) / STRIDE + 1,
  localparam int CH_W    = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
  localparam int POS_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_relu,
  input  logic signed [DW-1:0] i_data   [IN_CH*IN_LEN],
  input  logic signed [DW-1:0] i_kernel [OUT_CH*IN_CH*K_LEN],
  input  logic signed [DW-1:0] i_bias   [OUT_CH],
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OW-1:0]        o_data,
  output logic [CH_W-1:0]      o_ch,
  output logic [POS_W-1:0]     o_pos,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int N_DATA = IN_CH * IN_LEN;
  localparam int N_KERN = OUT_CH * IN_CH * K_LEN;
  localparam int AW     = 2 * DW + $clog2(IN_CH * K_LEN) + 1;
  localparam int IC_W   = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int K_W    = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam int DI_W   = (N_DATA > 1) ? $clog2(N_DATA) : 1;
  localparam int KI_W   = (N_KERN > 1) ? $clog2(N_KERN) : 1;

  state_t               state_reg;
  logic [CH_W-1:0]      oc_reg;
  logic [POS_W-1:0]     pos_reg;
  logic [IC_W-1:0]      ic_reg;
  logic [K_W-1:0]       k_reg;
  logic                 relu_reg;
  logic signed [DW-1:0] data_reg   [N_DATA];
  logic signed [DW-1:0] kernel_reg [N_KERN];
  logic signed [DW-1:0] bias_reg   [OUT_CH];

  logic                 capture;
  logic                 last_k;
  logic                 last_ic;
  logic                 last_pos;
  logic                 last_oc;
  logic                 mac_clear;
  logic                 mac_en;
  logic [DI_W-1:0]      data_idx;
  logic [KI_W-1:0]      kern_idx;
  logic signed [AW-1:0] acc;
  logic signed [DW-1:0] bias_sel;
  logic signed [63:0]   acc_ext;
  logic signed [63:0]   bias_ext;
  logic signed [63:0]   sum_ext;
  logic signed [OW-1:0] scaled;

  assign capture  = (state_reg == IDLE) && i_start;
  assign last_k   = (k_reg == K_W'(K_LEN - 1));
  assign last_ic  = (ic_reg == IC_W'(IN_CH - 1));
  assign last_pos = (pos_reg == POS_W'(OUT_LEN - 1));
  assign last_oc  = (oc_reg == CH_W'(OUT_CH - 1));

  // Every new (oc,pos) starts from a clean accumulator: on frame start and on each transfer.
  assign mac_clear = capture || ((state_reg == EMIT) && i_ready);
  assign mac_en    = (state_reg == MAC);

  assign data_idx = DI_W'(int'(ic_reg) * IN_LEN + int'(pos_reg) * STRIDE + int'(k_reg));
  assign kern_idx = KI_W'((int'(oc_reg) * IN_CH + int'(ic_reg)) * K_LEN + int'(k_reg));

  // Frame operands are latched once so the caller may change its inputs mid-frame.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      relu_reg <= i_relu;
      for (int i = 0; i < N_DATA; i++) begin
        data_reg[i] <= i_data[i];
      end
      for (int i = 0; i < N_KERN; i++) begin
        kernel_reg[i] <= i_kernel[i];
      end
      for (int i = 0; i < OUT_CH; i++) begin
        bias_reg[i] <= i_bias[i];
      end
    end
  end

  conv_mac #(
    .DW(DW),
    .AW(AW)
  ) u_mac (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (mac_clear),
    .enable(mac_en),
    .a     (data_reg[data_idx]),
    .b     (kernel_reg[kern_idx]),
    .acc   (acc)
  );

  // Bias is aligned to the product's Q16.16 scale before the single rescale shift.
  always_comb begin
    bias_sel = bias_reg[0];
    for (int i = 0; i < OUT_CH; i++) begin
      if (oc_reg == CH_W'(i)) begin
        bias_sel = bias_reg[i];
      end
    end
    acc_ext  = {{(64-AW){acc[AW-1]}}, acc};
    bias_ext = {{(64-DW){bias_sel[DW-1]}}, bias_sel};
    sum_ext  = acc_ext + (bias_ext <<< FRAC_BITS);
    scaled   = OW'(saturate(sum_ext >>> FRAC_BITS, OW));
    if (relu_reg && scaled[OW-1]) begin
      scaled = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      oc_reg    <= '0;
      pos_reg   <= '0;
      ic_reg    <= '0;
      k_reg     <= '0;
      o_valid   <= 1'b0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
      o_data    <= '0;
      o_ch      <= '0;
      o_pos     <= '0;
    end else begin
      o_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            oc_reg    <= '0;
            pos_reg   <= '0;
            ic_reg    <= '0;
            k_reg     <= '0;
            o_busy    <= 1'b1;
            state_reg <= MAC;
          end
        end
        MAC: begin
          if (last_k) begin
            k_reg <= '0;
            if (last_ic) begin
              ic_reg    <= '0;
              state_reg <= SCALE;
            end else begin
              ic_reg <= ic_reg + IC_W'(1);
            end
          end else begin
            k_reg <= k_reg + K_W'(1);
          end
        end
        SCALE: begin
          o_data    <= scaled;
          o_ch      <= oc_reg;
          o_pos     <= pos_reg;
          o_valid   <= 1'b1;
          state_reg <= EMIT;
        end
        EMIT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (last_oc && last_pos) begin
              o_done    <= 1'b1;
              state_reg <= DONE;
            end else begin
              if (last_pos) begin
                pos_reg <= '0;
                oc_reg  <= oc_reg + CH_W'(1);
              end else begin
                pos_reg <= pos_reg + POS_W'(1);
              end
              state_reg <= MAC;
            end
          end
        end
        DONE: begin
          o_busy    <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          o_valid   <= 1'b0;
          o_busy    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_stream.sv
// Bench for conv1d_stream: directed and random frames on a single-filter and a
// two-filter instance, each result compared with an arithmetic reference model.
module tb_conv1d_stream;

  localparam int IN_CH   = 4;
  localparam int IN_LEN  = 10;
  localparam int K_LEN   = 6;
  localparam int STRIDE  = 2;
  localparam int DW      = 16;
  localparam int OW      = 24;
  localparam int OUT_LEN = 3;
  localparam int LAT     = IN_CH * K_LEN + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start1;
  logic start2;
  logic relu_in;
  logic ready;
  logic signed [DW-1:0] din   [IN_CH*IN_LEN];
  logic signed [DW-1:0] kern1 [IN_CH*K_LEN];
  logic signed [DW-1:0] kern2 [2*IN_CH*K_LEN];
  logic signed [DW-1:0] bias1 [1];
  logic signed [DW-1:0] bias2 [2];

  logic          v1, done1, busy1, v2, done2, busy2;
  logic [OW-1:0] data1, data2;
  logic [0:0]    ch1, ch2;
  logic [1:0]    pos1, pos2;

  conv1d_stream #(.OUT_CH(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_relu(relu_in),
    .i_data(din), .i_kernel(kern1), .i_bias(bias1),
    .o_valid(v1), .i_ready(ready), .o_data(data1), .o_ch(ch1), .o_pos(pos1),
    .o_busy(busy1), .o_done(done1)
  );

  conv1d_stream #(.OUT_CH(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_relu(relu_in),
    .i_data(din), .i_kernel(kern2), .i_bias(bias2),
    .o_valid(v2), .i_ready(ready), .o_data(data2), .o_ch(ch2), .o_pos(pos2),
    .o_busy(busy2), .o_done(done2)
  );

  int            sel_r = 0;
  logic          valid, done, busy;
  logic [OW-1:0] odata;
  logic [0:0]    och;
  logic [1:0]    opos;

  always_comb begin
    if (sel_r == 1) begin
      valid = v2; done = done2; busy = busy2; odata = data2; och = ch2; opos = pos2;
    end else begin
      valid = v1; done = done1; busy = busy1; odata = data1; och = ch1; opos = pos1;
    end
  end

  int total = 0;
  int bad   = 0;

  logic [15:0] md [IN_CH*IN_LEN];
  logic [15:0] mk [2*IN_CH*K_LEN];
  logic [15:0] mb [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued dot product in Q16.16, bias added, floor-rescale, clamp, ReLU.
  function automatic logic [OW-1:0] model(input int oc, input int pos, input bit relu);
    longint s;
    s = 0;
    for (int ic = 0; ic < IN_CH; ic++) begin
      for (int k = 0; k < K_LEN; k++) begin
        s += longint'($signed(md[ic*IN_LEN + pos*STRIDE + k])) *
             longint'($signed(mk[(oc*IN_CH + ic)*K_LEN + k]));
      end
    end
    s += longint'($signed(mb[oc])) * 256;
    s = s >>> 8;
    if (s > 64'sd8388607) s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    if (relu && s < 0) s = 0;
    return s[OW-1:0];
  endfunction

  function automatic logic [15:0] rnd(input bit full);
    if (full) return 16'($urandom);
    return 16'($urandom_range(0, 1023) - 512);
  endfunction

  task automatic drive_start(input int sel, input logic val);
    if (sel == 1) start2 = val;
    else start1 = val;
  endtask

  task automatic load(input int sel);
    for (int i = 0; i < IN_CH*IN_LEN; i++) din[i] = md[i];
    if (sel == 1) begin
      for (int i = 0; i < 2*IN_CH*K_LEN; i++) kern2[i] = mk[i];
      bias2[0] = mb[0];
      bias2[1] = mb[1];
    end else begin
      for (int i = 0; i < IN_CH*K_LEN; i++) kern1[i] = mk[i];
      bias1[0] = mb[0];
    end
  endtask

  task automatic fill(input logic [15:0] d, input logic [15:0] k, input logic [15:0] b0,
                      input logic [15:0] b1);
    for (int i = 0; i < IN_CH*IN_LEN; i++) md[i] = d;
    for (int i = 0; i < 2*IN_CH*K_LEN; i++) mk[i] = k;
    mb[0] = b0;
    mb[1] = b1;
  endtask

  task automatic fill_rand(input bit full);
    for (int i = 0; i < IN_CH*IN_LEN; i++) md[i] = rnd(full);
    for (int i = 0; i < 2*IN_CH*K_LEN; i++) mk[i] = rnd(full);
    mb[0] = rnd(full);
    mb[1] = rnd(full);
  endtask

  task automatic run_frame(input int sel, input bit relu, input bit stall, input bit mid_start);
    int nout;
    int lat;
    logic [OW-1:0] expv;
    nout = (sel == 1) ? 2 : 1;
    sel_r = sel;
    load(sel);
    relu_in = relu;
    ready = !stall;
    drive_start(sel, 1'b1);
    for (int r = 0; r < nout*OUT_LEN; r++) begin
      expv = model(r / OUT_LEN, r % OUT_LEN, relu);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        drive_start(sel, 1'b0);
        if (lat == 1) chk("quiet_after_go", valid, 1'b0);
        if (mid_start && r == 0 && lat == 5) begin
          drive_start(sel, 1'b1);
          relu_in = ~relu_in;
          for (int i = 0; i < IN_CH*IN_LEN; i++) din[i] = 16'($urandom);
          for (int i = 0; i < IN_CH*K_LEN; i++) begin
            kern1[i] = 16'($urandom);
            kern2[i] = 16'($urandom);
          end
          bias1[0] = 16'($urandom);
          bias2[0] = 16'($urandom);
        end
      end while (!valid && lat < 200);
      chk("latency", lat, LAT);
      chk("data", odata, expv);
      chk("ch", och, r / OUT_LEN);
      chk("pos", opos, r % OUT_LEN);
      if (stall && r == 0) begin
        for (int s = 1; s < 5; s++) begin
          @(negedge clk);
          chk("stall_valid", valid, 1'b1);
          chk("stall_data", odata, expv);
          chk("stall_ch", och, 0);
          chk("stall_pos", opos, 0);
        end
        ready = 1'b1;
      end
      $display("frame sel=%0d result %0d ch=%0d pos=%0d data=%06h", sel, r, och, opos, odata);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    chk("done_latency", lat, 1);
    chk("busy_in_done", busy, 1'b1);
    drive_start(sel, 1'b1);
    @(negedge clk);
    drive_start(sel, 1'b0);
    chk("done_single", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
    @(negedge clk);
    chk("start_at_done_ignored", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    rst_n = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    relu_in = 1'b0;
    ready = 1'b1;
    fill(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    load(0);
    load(1);
    repeat (3) @(negedge clk);
    chk("rst_valid1", v1, 1'b0);
    chk("rst_done1", done1, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_data1", data1, 0);
    chk("rst_ch1", ch1, 0);
    chk("rst_pos1", pos1, 0);
    chk("rst_valid2", v2, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
    chk("rst_data2", data2, 0);
    $display("reset checked");
    rst_n = 1'b1;
    @(negedge clk);

    // All ones: 24 products of 1.0 each.
    fill(16'h0100, 16'h0100, 16'h0000, 16'h0000);
    run_frame(0, 1'b0, 1'b0, 1'b0);

    // Ramp on channel 0 only; distinguishes the stride.
    fill(16'h0000, 16'h0100, 16'h0000, 16'h0000);
    for (int t = 0; t < IN_LEN; t++) md[t] = 16'(t * 256);
    run_frame(0, 1'b0, 1'b0, 1'b0);

    // Negative results with and without ReLU.
    fill(16'hFF00, 16'h0100, 16'h0000, 16'h0000);
    run_frame(0, 1'b0, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b0, 1'b0);

    // Positive and negative saturation.
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_frame(0, 1'b0, 1'b0, 1'b0);
    fill(16'h8000, 16'h7FFF, 16'h0000, 16'h0000);
    run_frame(0, 1'b0, 1'b0, 1'b0);

    // Backpressure on the first result plus an ignored mid-frame start.
    fill_rand(1'b0);
    run_frame(0, 1'b0, 1'b1, 1'b1);

    // Two filters, second bias 1.0.
    fill(16'h0100, 16'h0100, 16'h0000, 16'h0100);
    run_frame(1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of MAC abandons the frame.
    fill_rand(1'b0);
    sel_r = 1;
    load(1);
    drive_start(1, 1'b1);
    repeat (11) begin
      @(negedge clk);
      drive_start(1, 1'b0);
    end
    chk("busy_before_reset", busy2, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy2, 1'b0);
    chk("reset_valid", v2, 1'b0);
    rst_n = 1'b1;
    vcount = 0;
    repeat (60) begin
      @(negedge clk);
      if (v2 || busy2) vcount++;
    end
    chk("no_activity_after_reset", vcount, 0);
    $display("reset mid-frame checked");
    run_frame(1, 1'b0, 1'b0, 1'b0);

    // Random frames on both instances.
    for (int f = 0; f < 6; f++) begin
      fill_rand(f[0]);
      run_frame(f % 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
